// File: rtl/sprite_anim_seq.sv
// sprite_anim_seq: frame-timed sprite animation sequencer with loop, ping-pong, one-shot and hold modes
module sprite_anim_seq #(
  parameter int NUM_FRAMES = 4,
  parameter int DATA_W = 24,
  parameter int PERIOD_W = 22,
  localparam int IW = NUM_FRAMES > 1 ? $clog2(NUM_FRAMES) : 1
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         start,
  input  logic                         enable,
  input  logic [1:0]                   mode,
  input  logic [PERIOD_W-1:0]          period,
  input  logic [NUM_FRAMES*DATA_W-1:0] frames_din,
  output logic [DATA_W-1:0]            pixel_dout,
  output logic [IW-1:0]                frame_idx,
  output logic                         busy,
  output logic                         seq_done,
  output logic                         cycle_wrap
);
  localparam logic [IW-1:0] LAST = IW'(NUM_FRAMES - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [PERIOD_W-1:0] cnt, cnt_n, pmax;
  logic [IW-1:0] idx_n, step;
  logic dir, dir_n, done_n, wrap_n, adv, last, up;
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      cnt <= '0;
      frame_idx <= '0;
      dir <= 1'b0;
      seq_done <= 1'b0;
      cycle_wrap <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      frame_idx <= idx_n;
      dir <= dir_n;
      seq_done <= done_n;
      cycle_wrap <= wrap_n;
    end
  end
  always_comb begin
    pmax = (period == '0) ? '0 : period - 1'b1;
    adv = state == RUN && enable && mode != 2'b11 && cnt >= pmax;
    last = frame_idx == LAST;
    up = dir ? frame_idx == '0 : !last;
    step = up ? frame_idx + 1'b1 : frame_idx - 1'b1;
    state_n = state;
    cnt_n = cnt;
    idx_n = frame_idx;
    dir_n = dir;
    done_n = 1'b0;
    wrap_n = 1'b0;
    if (start) begin
      state_n = RUN;
      cnt_n = '0;
      idx_n = '0;
      dir_n = 1'b0;
    end else if (state == RUN && enable) begin
      cnt_n = (mode == 2'b11 || adv) ? '0 : cnt + 1'b1;
      if (adv && mode == 2'b00) begin
        idx_n = last ? '0 : frame_idx + 1'b1;
        wrap_n = last;
      end
      if (adv && mode == 2'b01) begin
        idx_n = NUM_FRAMES == 1 ? '0 : step;
        dir_n = NUM_FRAMES == 1 ? 1'b0 : step == LAST ? 1'b1 : step == '0 ? 1'b0 : !up;
        wrap_n = NUM_FRAMES == 1 || step == '0;
      end
      if (adv && mode == 2'b10) begin
        idx_n = last ? frame_idx : frame_idx + 1'b1;
        state_n = last ? DONE : RUN;
        done_n = last;
      end
    end
  end
  assign busy = state == RUN;
  assign pixel_dout = frames_din[int'(frame_idx)*DATA_W +: DATA_W];
endmodule

// File: tb/tb_sprite_anim_seq.sv
// tb_sprite_anim_seq: directed checks plus a per-cycle behavioural model comparison
module tb_sprite_anim_seq;
  localparam int NF = 4;
  logic Clk = 0, Reset = 1, start = 0, enable = 1;
  logic [1:0] mode = 0;
  logic [21:0] period = 1;
  logic [NF*24-1:0] frames_din = {24'hC0FFEE, 24'h0F0F0F, 24'hABCDEF, 24'h123456};
  logic [23:0] pixel_dout;
  logic [1:0] frame_idx;
  logic busy, seq_done, cycle_wrap;
  int vectors = 0, miscompares = 0;
  bit armed = 0;
  int ms, mc, mi, md, p;
  bit mw, mdn;

  sprite_anim_seq dut (.Clk(Clk), .Reset(Reset), .start(start), .enable(enable), .mode(mode),
    .period(period), .frames_din(frames_din), .pixel_dout(pixel_dout), .frame_idx(frame_idx),
    .busy(busy), .seq_done(seq_done), .cycle_wrap(cycle_wrap));

  always #10 Clk = ~Clk;

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Model: ms 0 idle / 1 run / 2 done, md is +1 or -1 direction
  always @(posedge Clk) begin
    mw = 0;
    mdn = 0;
    p = (period == 0) ? 1 : int'(period);
    if (Reset) begin
      ms = 0; mc = 0; mi = 0; md = 1;
    end else if (start) begin
      ms = 1; mc = 0; mi = 0; md = 1;
    end else if (ms == 1 && enable) begin
      if (mode == 2'd3) mc = 0;
      else if (mc + 1 < p) mc++;
      else begin
        mc = 0;
        if (mode == 2'd0) begin
          mi = (mi + 1) % NF;
          mw = mi == 0;
        end else if (mode == 2'd1) begin
          if (mi + md < 0 || mi + md >= NF) md = -md;
          mi += md;
          if (mi == NF - 1) md = -1;
          if (mi == 0) begin md = 1; mw = 1; end
        end else if (mi == NF - 1) begin
          ms = 2; mdn = 1;
        end else mi++;
      end
    end
  end

  always @(posedge Clk) begin
    #1;
    if (armed) begin
      chk("m_idx", 32'(frame_idx), 32'(mi));
      chk("m_busy", 32'(busy), 32'(ms == 1));
      chk("m_done", 32'(seq_done), 32'(mdn));
      chk("m_wrap", 32'(cycle_wrap), 32'(mw));
      chk("m_pix", 32'(pixel_dout), 32'(frames_din[mi*24 +: 24]));
    end
  end

  task automatic pulse_start;
    start = 1;
    @(negedge Clk);
    start = 0;
  endtask

  initial begin
    int lidx[13] = '{0,0,0,1,1,1,2,2,2,3,3,3,0};
    int pidx[8] = '{0,1,2,3,2,1,0,1};
    int oidx[10] = '{0,0,1,1,2,2,3,3,3,3};
    repeat (2) @(negedge Clk);
    armed = 1;
    chk("rst_idx", 32'(frame_idx), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_pix", 32'(pixel_dout), 32'h123456);
    Reset = 0;
    @(negedge Clk);
    chk("idle_busy", 32'(busy), 0);
    mode = 0; period = 3;
    pulse_start;
    for (int i = 0; i < 13; i++) begin
      chk("loop_idx", 32'(frame_idx), 32'(lidx[i]));
      chk("loop_wrap", 32'(cycle_wrap), 32'(i == 12));
      @(negedge Clk);
    end
    mode = 1; period = 1;
    pulse_start;
    for (int i = 0; i < 8; i++) begin
      chk("pp_idx", 32'(frame_idx), 32'(pidx[i]));
      chk("pp_wrap", 32'(cycle_wrap), 32'(i == 6));
      @(negedge Clk);
    end
    mode = 2; period = 2;
    pulse_start;
    for (int i = 0; i < 10; i++) begin
      chk("os_idx", 32'(frame_idx), 32'(oidx[i]));
      chk("os_busy", 32'(busy), 32'(i < 8));
      chk("os_done", 32'(seq_done), 32'(i == 8));
      @(negedge Clk);
    end
    pulse_start;
    chk("os_restart_idx", 32'(frame_idx), 0);
    chk("os_restart_busy", 32'(busy), 1);
    mode = 0; period = 4;
    pulse_start;
    repeat (2) @(negedge Clk);
    enable = 0;
    repeat (10) @(negedge Clk);
    chk("pause_idx", 32'(frame_idx), 0);
    enable = 1;
    @(negedge Clk);
    chk("resume_idx0", 32'(frame_idx), 0);
    @(negedge Clk);
    chk("resume_idx1", 32'(frame_idx), 1);
    period = 8;
    pulse_start;
    repeat (5) @(negedge Clk);
    period = 3;
    @(negedge Clk);
    chk("period_shrink_idx", 32'(frame_idx), 1);
    mode = 3;
    repeat (6) @(negedge Clk);
    chk("hold_idx", 32'(frame_idx), 1);
    chk("hold_busy", 32'(busy), 1);
    mode = 0; period = 0;
    pulse_start;
    @(negedge Clk);
    chk("p0_idx1", 32'(frame_idx), 1);
    @(negedge Clk);
    chk("p0_idx2", 32'(frame_idx), 2);
    @(negedge Clk);
    chk("p0_idx3", 32'(frame_idx), 3);
    start = 1;
    @(negedge Clk);
    start = 0;
    chk("coinc_idx", 32'(frame_idx), 0);
    chk("coinc_wrap", 32'(cycle_wrap), 0);
    repeat (2) @(negedge Clk);
    chk("pre_rst_idx", 32'(frame_idx), 2);
    Reset = 1;
    @(negedge Clk);
    chk("midrst_idx", 32'(frame_idx), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_pix", 32'(pixel_dout), 32'h123456);
    Reset = 0;
    repeat (3) @(negedge Clk);
    chk("post_rst_idle", 32'(frame_idx), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/sprite_anim_seq.md
SPRITE_ANIM_SEQ -- requirements
Module: sprite_anim_seq

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  NUM_FRAMES, 4, animation frames, 1..16
  DATA_W, 24, pixel data width (RGB888)
  PERIOD_W, 22, width of frame-period counter
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  Clk  in  1  system clock, 50 MHz
  Reset  in  1  synchronous, active-high reset
  start  in  1  one-cycle pulse; (re)start animation at frame 0
  enable  in  1  1 = counting, 0 = paused (state/index frozen)
  mode  in  2  00 loop, 01 ping-pong, 10 one-shot, 11 hold
  period  in  PERIOD_W  Clk cycles per frame; 0 treated as 1
  frames_din  in  NUM_FRAMES*DATA_W  packed frame pixels, frame k at bits [k*DATA_W +: DATA_W]
  pixel_dout  out  DATA_W  pixel of current frame
  frame_idx  out  clog2(NUM_FRAMES) (min 1)  current frame index
  busy  out  1  1 while in RUN
  seq_done  out  1  one-cycle pulse: one-shot finished
  cycle_wrap  out  1  one-cycle pulse: index returned to 0 in loop/ping-pong
REQ-003 Clock SHALL be Clk; reset SHALL be Reset, synchronous, active-high.

Function
REQ-004 FSM states SHALL be IDLE, RUN, DONE.
REQ-005 IDLE: index held; start -> RUN with frame_idx=0, cnt=0, dir=up.
REQ-006 RUN: when enable=1, cnt SHALL increment each Clk; when cnt >= max(period,1)-1, cnt SHALL clear and one advance SHALL occur that cycle.
REQ-007 RUN with enable=0: cnt, frame_idx, dir and state SHALL hold; no pulses.
REQ-008 Loop advance: idx+1; at NUM_FRAMES-1 wrap to 0 and assert cycle_wrap for that cycle.
REQ-009 Ping-pong advance: dir up -> idx+1, dir down -> idx-1; on reaching NUM_FRAMES-1 dir SHALL flip to down, on reaching 0 dir SHALL flip to up and cycle_wrap SHALL pulse; end frames not repeated (0,1,2,3,2,1,0,1...).
REQ-010 One-shot advance: idx+1; an advance at NUM_FRAMES-1 SHALL move to DONE, hold idx=NUM_FRAMES-1, pulse seq_done one cycle.
REQ-011 Hold mode (11): no advances; cnt SHALL stay 0; state stays RUN.
REQ-012 mode SHALL be sampled at each advance; change mid-run takes effect on next advance from current idx; switching into ping-pong SHALL keep current dir.
REQ-013 NUM_FRAMES=1: idx stays 0; each advance in loop/ping-pong pulses cycle_wrap; one-shot goes to DONE on first advance.
REQ-014 DONE: idx held, busy=0; start -> RUN as REQ-005.
REQ-015 start in RUN or DONE SHALL restart per REQ-005 and take priority over a same-cycle advance; no seq_done/cycle_wrap that cycle.
REQ-016 pixel_dout SHALL be combinational: frames_din slice selected by registered frame_idx, zero latency.
REQ-017 period change mid-frame SHALL apply immediately; if cnt already >= new period-1, advance on next enabled cycle.
REQ-018 cnt SHALL be PERIOD_W bits and never wrap past period-1.

Reset
REQ-019 Reset SHALL force state=IDLE, cnt=0, frame_idx=0, dir=up, busy=0, seq_done=0, cycle_wrap=0; pixel_dout = frame 0 data.
REQ-020 Reset SHALL override start and any advance in the same cycle, including mid-run.

Verification
REQ-021 Loop: NUM_FRAMES=4, period=3, mode=00, start -> idx 0,1,2,3,0 changing every 3 Clk; cycle_wrap high exactly on the 3->0 cycle.
REQ-022 Ping-pong: period=1, mode=01 -> idx 0,1,2,3,2,1,0,1; cycle_wrap only on arrival at 0.
REQ-023 One-shot: period=2, mode=10 -> idx 0..3, then DONE 2 Clk after reaching 3; seq_done one cycle, busy=0, idx stays 3; start returns idx 0, busy=1.
REQ-024 Pause: period=4, drop enable for 10 Clk mid-frame -> idx and cnt frozen; resume completes remaining frame count exactly.
REQ-025 Edge cases: period=0 -> advance every Clk; start coincident with advance -> idx=0, no pulses; Reset asserted in RUN at idx=2 -> next cycle idx=0, IDLE, pixel_dout = frames_din[23:0].
